// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture path: widths, sample type and
// receiver FSM state encoding.
package i2s_pkg;

  localparam int I2S_SAMPLE_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH   = 32;

  typedef logic signed [I2S_SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    SYNC,
    DELAY,
    SHIFT,
    PAD
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for codec-domain signals. One input (the bit clock)
// also gets a rising-edge strobe; the companion bus is only synchronized so
// that it stays cycle-aligned with that strobe.
module i2s_sync_edge #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              edge_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              edge_rise,
  output logic [DATA_W-1:0] data_sync
);

  logic [1:0]        edge_meta;
  logic              edge_prev;
  logic [DATA_W-1:0] data_meta;

  // Two-stage synchronization of every input plus a delayed copy of the
  // synchronized edge signal for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_meta <= '0;
      edge_prev <= 1'b0;
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      edge_meta <= {edge_meta[0], edge_in};
      edge_prev <= edge_meta[1];
      data_meta <= data_in;
      data_sync <= data_meta;
    end
  end

  assign edge_rise = edge_meta[1] & ~edge_prev;

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture path for the SGTL5000 ADC. The codec is bus master; SCLK,
// LRCLK and SDATA are sampled on the system clock after synchronization and
// deserialized into left/right words, presented as a pair with one
// sample_valid pulse per stereo frame.
// Optional build macro I2S_RX_FRAME_CHECK_EN: slot-length checking with
// frame_error reporting and relock. Without it frame_error is constant 0.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    SCLK,
  input  logic                    LRCLK,
  input  logic                    SDATA,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    frame_error
);

  // Word capture must finish before the slot's final bit so the next slot
  // edge is never swallowed, even if the slot is configured too narrow.
  localparam int         LAST_BIT   = (SAMPLE_WIDTH < SLOT_WIDTH) ? SAMPLE_WIDTH - 1 : SLOT_WIDTH - 2;
  localparam logic [5:0] LAST_CNT   = 6'(LAST_BIT);
  localparam logic [5:0] BITCNT_MAX = 6'd63;

  logic                    sclk_rise;
  logic [1:0]              data_sync;
  logic                    lr_s;
  logic                    sdata_s;
  logic                    slot_edge;
  logic                    frame_bad;
  logic [SAMPLE_WIDTH-1:0] shift_next;

  i2s_rx_state_t           state;
  logic                    channel;
  logic                    lr_prev;
  logic [5:0]              bitcnt;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    left_filled;

  i2s_sync_edge #(
    .DATA_W(2)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .edge_in   (SCLK),
    .data_in   ({SDATA, LRCLK}),
    .edge_rise (sclk_rise),
    .data_sync (data_sync)
  );

  assign lr_s       = data_sync[0];
  assign sdata_s    = data_sync[1];
  assign slot_edge  = (lr_s != lr_prev);
  assign shift_next = {shreg[SAMPLE_WIDTH-2:0], sdata_s};

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [5:0] SLOT_LAST = 6'(SLOT_WIDTH - 1);

  // A locked slot is malformed when its length differs from SLOT_WIDTH or
  // when LRCLK stops toggling long enough for the bit counter to saturate.
  always_comb begin
    frame_bad = 1'b0;
    if (sclk_rise && (state == SHIFT || state == PAD)) begin
      if (slot_edge)
        frame_bad = (bitcnt != SLOT_LAST);
      else
        frame_bad = (bitcnt == BITCNT_MAX);
    end
  end
`else
  assign frame_bad = 1'b0;
`endif

  // Slot tracking, deserialization FSM and output registers. Every sampling
  // decision is taken on sclk_rise; the slot-edge bit is the I2S one-bit
  // delay and carries no data for the new channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC;
      channel      <= 1'b0;
      lr_prev      <= 1'b0;
      bitcnt       <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      left_filled  <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (sclk_rise) begin
        lr_prev <= lr_s;
        if (slot_edge)
          bitcnt <= '0;
        else if (bitcnt != BITCNT_MAX)
          bitcnt <= bitcnt + 6'd1;
      end

      if (frame_bad) begin
        frame_error <= 1'b1;
        locked      <= 1'b0;
        left_filled <= 1'b0;
        state       <= DELAY;
      end else begin
        case (state)
          SYNC: begin
            if (sclk_rise && slot_edge && !lr_s) begin
              state       <= SHIFT;
              channel     <= 1'b0;
              left_filled <= 1'b0;
              locked      <= 1'b1;
            end
          end
          DELAY: begin
            state <= SYNC;
          end
          SHIFT: begin
            if (sclk_rise) begin
              if (slot_edge) begin
                state       <= SHIFT;
                channel     <= lr_s;
                left_filled <= 1'b0;
              end else begin
                shreg <= shift_next;
                if (bitcnt == LAST_CNT) begin
                  state <= PAD;
                  if (!channel) begin
                    left_hold   <= shift_next;
                    left_filled <= 1'b1;
                  end else begin
                    left_filled <= 1'b0;
                    if (left_filled) begin
                      left_sample  <= left_hold;
                      right_sample <= shift_next;
                      sample_valid <= 1'b1;
                    end
                  end
                end
              end
            end
          end
          PAD: begin
            if (sclk_rise && slot_edge) begin
              state   <= SHIFT;
              channel <= lr_s;
              if (!lr_s)
                left_filled <= 1'b0;
            end
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed self-checking bench for i2s_receiver: drives an I2S master stream
// (SCLK about 16 system clocks per period) and checks captured pairs, lock,
// reset behaviour, pad-bit rejection and short-slot handling.
module tb_i2s_receiver;

  localparam int HB = 163;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        SCLK = 1'b0;
  logic        LRCLK = 1'b0;
  logic        SDATA = 1'b0;
  logic [23:0] left_sample;
  logic [23:0] right_sample;
  logic        sample_valid;
  logic        locked;
  logic        frame_error;

  int total = 0;
  int bad = 0;
  int validCount = 0;
  int errCount = 0;

  i2s_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .SCLK         (SCLK),
    .LRCLK        (LRCLK),
    .SDATA        (SDATA),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_error  (frame_error)
  );

  // 50 MHz-style system clock
  always #10 clk = ~clk;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (sample_valid) validCount++;
    if (frame_error) errCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One SCLK period: data and LRCLK change while SCLK is low, codec-style
  task automatic sendBit(input logic lr, input logic d);
    LRCLK = lr;
    SDATA = d;
    #HB SCLK = 1'b1;
    #HB SCLK = 1'b0;
  endtask

  // One channel slot of nbits SCLK periods: delay bit, word MSB first, pads
  task automatic applyStimulus(input logic lr, input logic [23:0] word, input int nbits, input logic pad);
    sendBit(lr, pad);
    for (int i = 1; i < nbits; i++) begin
      if (i <= 24) sendBit(lr, word[24-i]);
      else sendBit(lr, pad);
    end
  endtask

  task automatic sendFrame(input logic [23:0] l, input logic [23:0] r, input logic pad);
    applyStimulus(1'b0, l, 32, pad);
    applyStimulus(1'b1, r, 32, pad);
  endtask

  initial begin
    int base;
    int errBase;
    logic [23:0] w;
    logic expLocked;
    int expErr;

`ifdef I2S_RX_FRAME_CHECK_EN
    expLocked = 1'b0;
    expErr = 1;
`else
    expLocked = 1'b1;
    expErr = 0;
`endif

    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("rst_left", 32'(left_sample), 32'h0);
    checkOutput("rst_right", 32'(right_sample), 32'h0);
    checkOutput("rst_valid", 32'(sample_valid), 32'h0);
    checkOutput("rst_locked", 32'(locked), 32'h0);
    checkOutput("rst_ferr", 32'(frame_error), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Basic stream: lock on first LRCLK 1->0, one pulse per frame
    base = validCount;
    errBase = errCount;
    applyStimulus(1'b1, 24'h000000, 32, 1'b0);
    checkOutput("t1_unlocked", 32'(locked), 32'h0);
    applyStimulus(1'b0, 24'h123456, 32, 1'b0);
    checkOutput("t1_locked", 32'(locked), 32'h1);
    checkOutput("t1_no_pulse_left", 32'(validCount - base), 32'd0);
    applyStimulus(1'b1, 24'hABCDEF, 32, 1'b0);
    checkOutput("t1_pulse1", 32'(validCount - base), 32'd1);
    checkOutput("t1_left", 32'(left_sample), 32'h123456);
    checkOutput("t1_right", 32'(right_sample), 32'hABCDEF);
    sendFrame(24'h123456, 24'hABCDEF, 1'b0);
    sendFrame(24'h123456, 24'hABCDEF, 1'b0);
    checkOutput("t1_pulse3", 32'(validCount - base), 32'd3);
    checkOutput("t1_ferr", 32'(errCount - errBase), 32'd0);

    // Stream starting mid right slot
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    base = validCount;
    w = 24'hA5C3F1;
    for (int i = 11; i >= 0; i--) sendBit(1'b1, w[i]);
    checkOutput("t2_no_early", 32'(validCount - base), 32'd0);
    sendFrame(24'h0F1E2D, 24'h3C4B5A, 1'b0);
    checkOutput("t2_pulse", 32'(validCount - base), 32'd1);
    checkOutput("t2_left", 32'(left_sample), 32'h0F1E2D);
    checkOutput("t2_right", 32'(right_sample), 32'h3C4B5A);

    // Reset for 2 clk mid left slot
    base = validCount;
    w = 24'h654321;
    sendBit(1'b0, 1'b0);
    for (int i = 23; i >= 14; i--) sendBit(1'b0, w[i]);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checkOutput("t3_rst_left", 32'(left_sample), 32'h0);
    checkOutput("t3_rst_right", 32'(right_sample), 32'h0);
    checkOutput("t3_rst_locked", 32'(locked), 32'h0);
    @(negedge clk) reset = 1'b0;
    for (int i = 13; i >= 0; i--) sendBit(1'b0, w[i]);
    for (int i = 0; i < 7; i++) sendBit(1'b0, 1'b0);
    applyStimulus(1'b1, 24'h111111, 32, 1'b0);
    checkOutput("t3_no_partial", 32'(validCount - base), 32'd0);
    sendFrame(24'h654321, 24'hFEDCBA, 1'b0);
    checkOutput("t3_pulse", 32'(validCount - base), 32'd1);
    checkOutput("t3_left", 32'(left_sample), 32'h654321);
    checkOutput("t3_right", 32'(right_sample), 32'hFEDCBA);

    // Extreme values with pad bits all ones
    base = validCount;
    sendFrame(24'h800000, 24'h7FFFFF, 1'b1);
    checkOutput("t4_pulse", 32'(validCount - base), 32'd1);
    checkOutput("t4_left", 32'(left_sample), 32'h800000);
    checkOutput("t4_right", 32'(right_sample), 32'h7FFFFF);

    // Short left slot: 20 SCLKs cuts the word off before its last bit
    base = validCount;
    errBase = errCount;
    applyStimulus(1'b0, 24'h222222, 20, 1'b0);
    applyStimulus(1'b1, 24'h333333, 32, 1'b0);
    checkOutput("t5_dropped", 32'(validCount - base), 32'd0);
    checkOutput("t5_ferr", 32'(errCount - errBase), 32'(expErr));
    checkOutput("t5_locked", 32'(locked), 32'(expLocked));
    checkOutput("t5_keep_left", 32'(left_sample), 32'h800000);
    sendFrame(24'h444444, 24'h555555, 1'b0);
    sendFrame(24'hC0FFEE, 24'h0BADF0, 1'b0);
    checkOutput("t5_recover", 32'(validCount - base), 32'd2);
    checkOutput("t5_relocked", 32'(locked), 32'h1);
    checkOutput("t5_left", 32'(left_sample), 32'hC0FFEE);
    checkOutput("t5_right", 32'(right_sample), 32'h0BADF0);
    checkOutput("t5_ferr_total", 32'(errCount - errBase), 32'(expErr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
